// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

   typedef struct packed {
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       rw;
      logic       mr;
   } stage_t;

   localparam stage_t BUBBLE = '0;

   typedef enum logic [1:0] {
      ADV_HOLD,
      ADV_BUBBLE,
      ADV_LOAD
   } adv_t;

   // x0 is hardwired, so a producer of x0 never creates a dependency.
   function automatic logic reg_match(input logic [4:0] r, input logic [4:0] s, input logic use_s);
      return (r != 5'd0) && (r == s) && use_s;
   endfunction

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select for one EX operand; EX/MEM beats MEM/WB.
// Latency: combinational.
// Backpressure: none.
module fwd_unit
   import hazard_ctrl_pkg::*;
(
   input  logic [4:0] ex_rs,
   input  logic [4:0] mem_rd,
   input  logic       mem_rw,
   input  logic [4:0] wb_rd,
   input  logic       wb_rw,
   output logic [1:0] fwd
);

   always_comb begin
      fwd = FWD_REG;
      if (mem_rw && reg_match(mem_rd, ex_rs, 1'b1)) begin
         fwd = FWD_MEM;
      end else if (wb_rw && reg_match(wb_rd, ex_rs, 1'b1)) begin
         fwd = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: stall/flush/bubble/freeze, PC select and EX forwarding.
// Latency: controls combinational from shadows + ID inputs; shadows update each clock.
// Backpressure: dmem_busy_i freezes all shadows and holds PC and IF/ID.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_use_rs1_i,
   input  logic             id_use_rs2_i,
   input  logic [4:0]       id_rd_i,
   input  logic             id_regwrite_i,
   input  logic             id_memread_i,
   input  logic             id_branch_i,
   input  logic             id_branch_taken_i,
   input  logic             dmem_busy_i,
   output logic             pc_write_o,
   output logic             pc_sel_o,
   output logic             if_stall_o,
   output logic             if_flush_o,
   output logic             noop_o,
   output logic             freeze_o,
   output logic [1:0]       fwd_a_o,
   output logic [1:0]       fwd_b_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   logic             started_q;
   stage_t           ex_q;
   logic [4:0]       mem_rd_q;
   logic             mem_rw_q;
   logic             mem_mr_q;
   logic [4:0]       wb_rd_q;
   logic             wb_rw_q;
   logic [CNT_W-1:0] stall_cnt_q;

   logic   ex_hit;
   logic   mem_hit;
   logic   load_use;
   logic   br_hz;
   logic   hz;
   logic   br_taken;
   adv_t   adv;
   stage_t id_stage;

   assign ex_hit   = reg_match(ex_q.rd, id_rs1_i, id_use_rs1_i) ||
                     reg_match(ex_q.rd, id_rs2_i, id_use_rs2_i);
   assign mem_hit  = reg_match(mem_rd_q, id_rs1_i, id_use_rs1_i) ||
                     reg_match(mem_rd_q, id_rs2_i, id_use_rs2_i);
   assign load_use = ex_q.mr && ex_hit;
   // Branches compare in ID, so an ALU result still in EX or a load still in MEM is too late.
   assign br_hz    = id_branch_i && ((ex_q.rw && ex_hit) || (mem_mr_q && mem_hit));
   assign hz       = load_use || br_hz;
   assign br_taken = id_branch_i && id_branch_taken_i;

   always_comb begin
      id_stage.rd  = id_rd_i;
      id_stage.rs1 = id_use_rs1_i ? id_rs1_i : 5'd0;
      id_stage.rs2 = id_use_rs2_i ? id_rs2_i : 5'd0;
      id_stage.rw  = id_regwrite_i && !br_taken;
      id_stage.mr  = id_memread_i;
   end

   always_comb begin
      pc_write_o = 1'b0;
      pc_sel_o   = 1'b0;
      if_stall_o = 1'b0;
      if_flush_o = 1'b0;
      noop_o     = 1'b0;
      freeze_o   = 1'b0;
      adv        = ADV_HOLD;
      if (!started_q) begin
         if_stall_o = 1'b1;
         noop_o     = 1'b1;
      end else if (dmem_busy_i) begin
         freeze_o   = 1'b1;
         if_stall_o = 1'b1;
      end else if (hz) begin
         if_stall_o = 1'b1;
         noop_o     = 1'b1;
         adv        = ADV_BUBBLE;
      end else if (br_taken) begin
         pc_sel_o   = 1'b1;
         pc_write_o = 1'b1;
         if_flush_o = 1'b1;
         adv        = ADV_LOAD;
      end else begin
         pc_write_o = 1'b1;
         adv        = ADV_LOAD;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         started_q   <= 1'b0;
         ex_q        <= BUBBLE;
         mem_rd_q    <= 5'd0;
         mem_rw_q    <= 1'b0;
         mem_mr_q    <= 1'b0;
         wb_rd_q     <= 5'd0;
         wb_rw_q     <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         started_q <= started_q | start_i;
         if (started_q && !pc_write_o && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
         if (adv != ADV_HOLD) begin
            ex_q     <= (adv == ADV_BUBBLE) ? BUBBLE : id_stage;
            mem_rd_q <= ex_q.rd;
            mem_rw_q <= ex_q.rw;
            mem_mr_q <= ex_q.mr;
            wb_rd_q  <= mem_rd_q;
            wb_rw_q  <= mem_rw_q;
         end
      end
   end

   assign stall_cnt_o = stall_cnt_q;

   fwd_unit u_fwd_a (
      .ex_rs  (ex_q.rs1),
      .mem_rd (mem_rd_q),
      .mem_rw (mem_rw_q),
      .wb_rd  (wb_rd_q),
      .wb_rw  (wb_rw_q),
      .fwd    (fwd_a_o)
   );

   fwd_unit u_fwd_b (
      .ex_rs  (ex_q.rs2),
      .mem_rd (mem_rd_q),
      .mem_rw (mem_rw_q),
      .wb_rd  (wb_rd_q),
      .wb_rw  (wb_rw_q),
      .fwd    (fwd_b_o)
   );

endmodule
